// File: rtl/lsu_mem_port_if.sv
// Signal bundle between the load/store unit and its environment: issue, squash, memory, writeback, trap, status.
// Modport master is the LSU side; modport slave is the pipeline/memory side.
interface lsu_mem_port_if #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 12,
    parameter int RA_W  = 5
);
    logic                iss_valid;
    logic                iss_ready;
    logic                iss_is_load;
    logic [1:0]          iss_size;
    logic                iss_zero_ext;
    logic [RA_W-1:0]     iss_rd;
    logic [XLEN-1:0]     iss_base;
    logic [IMM_W-1:0]    iss_imm;
    logic [XLEN-1:0]     iss_wdata;
    logic                squash;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_be;
    logic                mem_resp_valid;
    logic [XLEN-1:0]     mem_rdata;
    logic                wb_valid;
    logic [RA_W-1:0]     wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                err_valid;
    logic [XLEN-1:0]     err_addr;
    logic                busy;

    modport master (
        input  iss_valid, iss_is_load, iss_size, iss_zero_ext, iss_rd, iss_base, iss_imm, iss_wdata,
        input  squash, mem_req_ready, mem_resp_valid, mem_rdata,
        output iss_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output wb_valid, wb_rd, wb_data, err_valid, err_addr, busy
    );

    modport slave (
        output iss_valid, iss_is_load, iss_size, iss_zero_ext, iss_rd, iss_base, iss_imm, iss_wdata,
        output squash, mem_req_ready, mem_resp_valid, mem_rdata,
        input  iss_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  wb_valid, wb_rd, wb_data, err_valid, err_addr, busy
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port: address generation, byte-lane steering, load extension, squash handling.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise low address bits are forced to zero.
module lsu_mem_port #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 12,
    parameter int RA_W  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_port_if.master bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_wb_data;
    logic [XLEN-1:0]   r_err_addr;
    logic [RA_W-1:0]   r_rd;
    logic [RA_W-1:0]   r_wb_rd;
    logic [1:0]        r_size;
    logic              r_is_load;
    logic              r_zext;
    logic              r_wb_valid;
    logic              r_err_valid;

    logic [XLEN-1:0]   w_ea;
    logic [XLEN-1:0]   w_ea_aligned;
    logic [XLEN-1:0]   w_lane;
    logic [XLEN-1:0]   w_wdata;
    logic [NB-1:0]     w_be_base;
    logic [NB-1:0]     w_be;
    logic [1:0]        w_size;
    logic              w_fire;
    logic              w_trap;

    function automatic logic [2:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] lane,
        input logic [1:0]      size,
        input logic            zext
    );
        logic [XLEN-1:0] m;
        logic            sgn;
        case (size)
            2'd0:    begin m = XLEN'(16'h00FF);      sgn = lane[7];  end
            2'd1:    begin m = XLEN'(16'hFFFF);      sgn = lane[15]; end
            2'd2:    begin m = XLEN'(32'hFFFF_FFFF); sgn = lane[31]; end
            default: begin m = {XLEN{1'b1}};         sgn = 1'b0;     end
        endcase
        load_extend = (lane & m) | ((sgn && !zext) ? ~m : {XLEN{1'b0}});
    endfunction

    // A doubleword request on a 32-bit port degrades to a word access.
    assign w_size       = (XLEN == 32 && bus.iss_size == 2'd3) ? 2'd2 : bus.iss_size;
    assign w_ea         = bus.iss_base + {{(XLEN-IMM_W){bus.iss_imm[IMM_W-1]}}, bus.iss_imm};
    assign w_ea_aligned = w_ea & ~{{(XLEN-3){1'b0}}, size_mask(w_size)};
    assign w_fire       = bus.iss_valid && bus.iss_ready;
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap       = w_fire && (|(w_ea[2:0] & size_mask(w_size)));
`else
    assign w_trap       = 1'b0;
`endif
    assign w_lane       = bus.mem_rdata >> {r_addr[OFF_W-1:0], 3'b000};

    assign bus.iss_ready     = (r_state == IDLE) && !bus.squash;
    assign bus.busy          = (r_state != IDLE);
    assign bus.mem_req_valid = (r_state == REQ) && !bus.squash;
    assign bus.mem_we        = (r_state == REQ) && !r_is_load;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = w_wdata;
    assign bus.mem_be        = w_be;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_rd         = r_wb_rd;
    assign bus.wb_data       = r_wb_data;
    assign bus.err_valid     = r_err_valid;
    assign bus.err_addr      = r_err_addr;

    // Byte enables and store data replicated across every lane of the access size.
    always_comb begin
        w_wdata = {XLEN{1'b0}};
        case (r_size)
            2'd0:    w_be_base = NB'(8'h01);
            2'd1:    w_be_base = NB'(8'h03);
            2'd2:    w_be_base = NB'(8'h0F);
            default: w_be_base = NB'(8'hFF);
        endcase
        if (r_state == REQ) begin
            w_be = w_be_base << r_addr[OFF_W-1:0];
        end else begin
            w_be = {NB{1'b0}};
        end
        for (int i = 0; i < NB; i++) begin
            case (r_size)
                2'd0:    w_wdata[8*i +: 8] = r_wdata[7:0];
                2'd1:    w_wdata[8*i +: 8] = r_wdata[8*(i%2) +: 8];
                2'd2:    w_wdata[8*i +: 8] = r_wdata[8*(i%4) +: 8];
                default: w_wdata[8*i +: 8] = r_wdata[8*i +: 8];
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a response coinciding with squash is consumed and dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire && !w_trap) w_next = REQ;
                else                   w_next = IDLE;
            end
            REQ: begin
                if (bus.squash)             w_next = IDLE;
                else if (bus.mem_req_ready) w_next = r_is_load ? WAIT : IDLE;
                else                        w_next = REQ;
            end
            WAIT: begin
                if (bus.mem_resp_valid) w_next = IDLE;
                else if (bus.squash)    w_next = DRAIN;
                else                    w_next = WAIT;
            end
            DRAIN: begin
                if (bus.mem_resp_valid) w_next = IDLE;
                else                    w_next = DRAIN;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operation latch, writeback and trap pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= {XLEN{1'b0}};
            r_wdata     <= {XLEN{1'b0}};
            r_size      <= 2'd0;
            r_is_load   <= 1'b0;
            r_zext      <= 1'b0;
            r_rd        <= {RA_W{1'b0}};
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= {RA_W{1'b0}};
            r_wb_data   <= {XLEN{1'b0}};
            r_err_valid <= 1'b0;
            r_err_addr  <= {XLEN{1'b0}};
        end else begin
            r_wb_valid  <= 1'b0;
            r_err_valid <= 1'b0;
            if (w_fire) begin
                if (w_trap) begin
                    r_err_valid <= 1'b1;
                    r_err_addr  <= w_ea;
                end else begin
                    r_addr    <= w_ea_aligned;
                    r_wdata   <= bus.iss_wdata;
                    r_size    <= w_size;
                    r_is_load <= bus.iss_is_load;
                    r_zext    <= bus.iss_zero_ext;
                    r_rd      <= bus.iss_rd;
                end
            end
            if (r_state == WAIT && bus.mem_resp_valid && !bus.squash) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_data  <= load_extend(w_lane, r_size, r_zext);
            end
        end
    end
endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter IMM_W, default 12, signed offset width.
REQ-003 Parameter RA_W, default 5, register-address width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 iss_valid in 1, iss_ready out 1: issue handshake; transfer when both high.
REQ-007 iss_is_load in 1, iss_size in 2 (0=B,1=H,2=W,3=D), iss_zero_ext in 1, iss_rd in RA_W: operation attributes.
REQ-008 iss_base in XLEN, iss_imm in IMM_W, iss_wdata in XLEN: base register, signed offset, store data.
REQ-009 squash in 1: branch squash; cancels the in-flight operation.
REQ-010 mem_req_valid out 1, mem_req_ready in 1, mem_we out 1, mem_addr out XLEN, mem_wdata out XLEN, mem_be out XLEN/8: memory request channel.
REQ-011 mem_resp_valid in 1, mem_rdata in XLEN: load response; no backpressure.
REQ-012 wb_valid out 1, wb_rd out RA_W, wb_data out XLEN: register-file write, one-cycle pulse.
REQ-013 err_valid out 1, err_addr out XLEN: misalignment trap, one-cycle pulse.
REQ-014 busy out 1: high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, REQ, WAIT, DRAIN; iss_ready = (state==IDLE) && !squash.
REQ-016 On issue transfer: effective address = iss_base + sign-extended iss_imm, modulo 2^XLEN; latch attributes; next state REQ.
REQ-017 When XLEN==32, size 3 is treated as size 2.
REQ-018 REQ: mem_req_valid = !squash; mem_addr = latched address; mem_we = !is_load; mem_be = size-wide mask shifted by addr[log2(XLEN/8)-1:0]; mem_wdata = store data replicated to the byte lane.
REQ-019 REQ with mem_req_ready && !squash: store -> IDLE; load -> WAIT.
REQ-020 REQ with squash: no request transfers; next state IDLE.
REQ-021 WAIT with mem_resp_valid && !squash: next cycle wb_valid=1, wb_rd=latched rd, wb_data = selected lane, sign- or zero-extended per zero_ext; state IDLE.
REQ-022 WAIT with squash and no response: -> DRAIN; DRAIN discards the next response, then -> IDLE; squash and response in same cycle: discard, -> IDLE.
REQ-023 Store or squashed load never produces wb_valid; rd==0 still produces wb_valid.
REQ-024 Minimum load latency: issue cycle N, request N+1 (if ready), response N+2, wb_valid N+3.
REQ-025 Maximum one operation outstanding; mem_resp_valid outside WAIT/DRAIN is ignored.

Reset
REQ-026 rst low asynchronously forces IDLE; wb_valid, err_valid, mem_req_valid, busy = 0; all data outputs = 0.
REQ-027 Reset mid-operation abandons it; a response arriving after reset release is ignored.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: address not aligned to access size -> no memory request, err_valid=1 and err_addr=address the cycle after issue, state stays IDLE.
REQ-029 Macro undefined: address low bits below access size are forced to zero, err_valid and err_addr tied 0.

Verification
REQ-030 XLEN=32, base=0x1000, imm=-4, store W 0xDEADBEEF, ready=1 -> mem_addr=0x0FFC, mem_be=4'b1111, mem_we=1, no wb_valid.
REQ-031 Load B addr 0x1003, rdata 0x80xxxxxx, zero_ext=0 -> wb_data=0xFFFFFF80; zero_ext=1 -> 0x00000080; wb at issue+3.
REQ-032 mem_req_ready low 5 cycles then high -> mem_req_valid/addr stable throughout; iss_ready low until completion.
REQ-033 Load in WAIT, squash, response 2 cycles later -> no wb_valid; next issue accepted after DRAIN exits.
REQ-034 TRAP_EN defined, load H at 0x1001 -> err_valid=1, err_addr=0x1001, mem_req_valid stays 0; undefined -> mem_addr=0x1000.
REQ-035 XLEN=64, load D at 0x8, rdata 0x0123456789ABCDEF -> wb_data=0x0123456789ABCDEF; rst low in WAIT -> all outputs 0 immediately.
